// File: rtl/pc_branch_unit_pkg.sv
// ============================================================================
// Module      : pc_branch_unit_pkg
// Description : Shared pipeline constants and helpers for the fetch stage.
//               Contents: XLEN, the NOP word, the jump-index field position,
//               the PC-source selector enum and the jump-target helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_branch_unit_pkg;

    localparam int XLEN = 32;

    // Instruction word used to flush IF/ID.
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    // Jump index field inside a J-type instruction word.
    localparam int JIDX_MSB = 25;
    localparam int JIDX_LSB = 0;
    localparam int JIDX_W   = JIDX_MSB - JIDX_LSB + 1;

    // Which source feeds the PC register on the next edge.
    typedef enum logic [1:0] {
        PC_SEL_SEQ    = 2'd0,
        PC_SEL_BRANCH = 2'd1,
        PC_SEL_JUMP   = 2'd2,
        PC_SEL_HOLD   = 2'd3
    } pc_sel_e;

    // Jump keeps the 256 MB region of the delay-slot PC and replaces the rest.
    function automatic logic [XLEN-1:0] jump_target(
        input logic [3:0]        region,
        input logic [JIDX_W-1:0] idx
    );
        return {region, idx, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_branch_unit_next_pc_sel.sv
// ============================================================================
// Module      : pc_branch_unit_next_pc_sel
// Description : Combinational branch/jump target computation and next-PC
//               priority mux (stall > jump > branch > sequential).
// Ports       : pc, if_id_pc4, imm_ext, jidx, controls in;
//               pc_next, pc_plus4, taken out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_branch_unit_next_pc_sel
    import pc_branch_unit_pkg::*;
(
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   if_id_pc4,
    input  logic [XLEN-1:0]   imm_ext,
    input  logic [JIDX_W-1:0] jidx,
    input  logic              stall,
    input  logic              branch,
    input  logic              branch_ne,
    input  logic              equal,
    input  logic              jump,
    output logic [XLEN-1:0]   pc_next,
    output logic [XLEN-1:0]   pc_plus4,
    output logic              taken
);

    logic    br_cond;
    pc_sel_e sel;

    always_comb begin
        pc_plus4 = pc + 32'd4;
        // bne takes on inequality, beq on equality.
        br_cond  = branch & (equal ^ branch_ne);
        taken    = ~stall & (jump | br_cond);

        if (stall) begin
            sel = PC_SEL_HOLD;
        end else if (jump) begin
            sel = PC_SEL_JUMP;
        end else if (br_cond) begin
            sel = PC_SEL_BRANCH;
        end else begin
            sel = PC_SEL_SEQ;
        end

        case (sel)
            PC_SEL_HOLD:   pc_next = pc;
            PC_SEL_JUMP:   pc_next = jump_target(if_id_pc4[XLEN-1:XLEN-4], jidx);
            PC_SEL_BRANCH: pc_next = if_id_pc4 + (imm_ext << 2);
            default:       pc_next = pc_plus4;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pc_branch_unit.sv
// ============================================================================
// Module      : pc_branch_unit
// Description : Fetch-side PC register and IF/ID pipeline register. Redirects
//               on taken branch/jump resolved in ID and flushes the single
//               wrong-path fetch with NOP_INSTR.
// Ports       : clk, rst_n (async, active-low), instr_in, stall, branch,
//               branch_ne, equal, jump, imm_ext in; pc, if_id_instr,
//               if_id_pc4, taken, br_count, br_taken_count out.
// Config      : BRANCH_STATS_EN - enables branch resolved/taken counters;
//               when undefined both counter outputs are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = pc_branch_unit_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] instr_in,
    input  logic            stall,
    input  logic            branch,
    input  logic            branch_ne,
    input  logic            equal,
    input  logic            jump,
    input  logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc4,
    output logic            taken,
    output logic [XLEN-1:0] br_count,
    output logic [XLEN-1:0] br_taken_count
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
    logic [XLEN-1:0] if_id_pc4_q, if_id_pc4_d;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_plus4;

    pc_branch_unit_next_pc_sel u_next_pc_sel (
        .pc        (pc_q),
        .if_id_pc4 (if_id_pc4_q),
        .imm_ext   (imm_ext),
        .jidx      (if_id_instr_q[JIDX_MSB:JIDX_LSB]),
        .stall     (stall),
        .branch    (branch),
        .branch_ne (branch_ne),
        .equal     (equal),
        .jump      (jump),
        .pc_next   (pc_next),
        .pc_plus4  (pc_plus4),
        .taken     (taken)
    );

    always_comb begin
        pc_d          = pc_next;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if (!stall) begin
            // The instruction fetched alongside a redirect is on the wrong path.
            if_id_instr_d = taken ? NOP_INSTR : instr_in;
            if_id_pc4_d   = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc4_q   <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
        end
    end

    assign pc          = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc4   = if_id_pc4_q;

`ifdef BRANCH_STATS_EN
    logic [XLEN-1:0] br_count_q, br_count_d;
    logic [XLEN-1:0] br_taken_count_q, br_taken_count_d;
    logic            stat_br_cond;

    // Counted even when a simultaneous jump wins the redirect.
    always_comb begin
        stat_br_cond     = branch & (equal ^ branch_ne);
        br_count_d       = br_count_q;
        br_taken_count_d = br_taken_count_q;
        if (!stall && branch) begin
            br_count_d = br_count_q + 32'd1;
            if (stat_br_cond) begin
                br_taken_count_d = br_taken_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q       <= '0;
            br_taken_count_q <= '0;
        end else begin
            br_count_q       <= br_count_d;
            br_taken_count_q <= br_taken_count_d;
        end
    end

    assign br_count       = br_count_q;
    assign br_taken_count = br_taken_count_q;
`else
    assign br_count       = '0;
    assign br_taken_count = '0;
`endif

endmodule

`default_nettype wire

// File: doc/pc_branch_unit.md
# pc_branch_unit

Fetch-side program-counter and IF/ID register stage for the 32-bit MIPS pipeline. It consumes the ID-stage 32-bit equality comparator result together with decoded branch/jump controls. It redirects the PC and flushes the fetched instruction on a taken branch or jump. It also owns the IF/ID pipeline register that feeds decode.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0000: instruction word injected into IF/ID on flush and reset.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `instr_in` input 32: instruction memory read data for the current `pc`, combinational read.
- `stall` input 1: hazard unit hold request; holds PC and IF/ID.
- `branch` input 1: instruction in ID is a conditional branch.
- `branch_ne` input 1: branch is bne (1) or beq (0).
- `equal` input 1: comparator result for the ID-stage operands.
- `jump` input 1: instruction in ID is j.
- `imm_ext` input 32: sign-extended 16-bit branch offset from ID.
- `pc` output 32: current fetch address. Reset value RESET_PC.
- `if_id_instr` output 32: instruction presented to decode. Reset value NOP_INSTR.
- `if_id_pc4` output 32: PC+4 of the instruction in ID. Reset value 0.
- `taken` output 1: combinational. Branch or jump redirect is taken this cycle.
- `br_count` output 32: resolved branches, counted only under the macro. Reset value 0.
- `br_taken_count` output 32: taken branches, counted only under the macro. Reset value 0.

## Operation
- Sequential next PC = `pc + 4`, modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is silent.
- Branch target = `if_id_pc4 + (imm_ext << 2)`, modulo 2^32.
- Jump target = {`if_id_pc4[31:28]`, `if_id_instr[25:0]`, 2'b00}.
- Branch condition: `br_cond = branch & (equal ^ branch_ne)`.
- `taken = ~stall & (jump | br_cond)`.
- Per-edge priority:
  1. reset
  2. `stall`: PC and IF/ID hold; no redirect; counters hold.
  3. `jump`: PC <= jump target.
  4. `br_cond`: PC <= branch target.
  5. Otherwise: PC <= pc+4.
- IF/ID register:
  - On a taken edge: `if_id_instr <= NOP_INSTR` (flushes the wrong-path fetch) and `if_id_pc4 <= pc+4`.
  - Otherwise, when not stalled: `if_id_instr <= instr_in` and `if_id_pc4 <= pc+4`.
- Jump and branch asserted together: jump wins. Both counters still update for the branch: resolved +1, taken +1 only if `br_cond`.
- Reset mid-operation: all registers are forced to their reset values immediately. The first fetch after release is RESET_PC.

## Timing
- Fetch: `pc` is valid after the clock edge. `instr_in` is sampled at the next edge into IF/ID, so there is 1 cycle from PC to decode.
- Branch and jump resolve in ID. Redirect lands on the edge after `taken` is sampled high.
- Exactly one wrong-path instruction is fetched and flushed, so the penalty is 1 cycle.
- Stall holds every register for as many cycles as it is asserted. `taken` is forced 0 while stalled. Resolution happens on the first unstalled cycle.
- Release of `rst_n` is asynchronous to `clk`. The reset-value PC appears on `pc` during reset.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `br_count` increments on every unstalled edge with `branch`=1.
  - `br_taken_count` increments when additionally `br_cond`=1.
  - Both are 32-bit and wrap at 2^32.
- Not defined: both counter outputs are tied to 0 and no counter flops exist.

## Structure
- The shared pipeline package holds:
  - the width constant `XLEN` = 32
  - `NOP_INSTR`
  - the instruction-field positions for the jump index (bits 25:0).
- One sub-module is natural: `next_pc_sel`, the combinational target computation and priority mux. The PC, IF/ID and counter registers stay in the top.

## Test plan
- Reset, then run 3 unstalled cycles with `instr_in`=32'h2008_0005 → `pc` steps 0, 4, 8, 12; `if_id_pc4`=4 after the first edge; `if_id_instr`=32'h2008_0005.
- beq taken: `if_id_pc4`=32'h10, `imm_ext`=32'hFFFF_FFFE, `equal`=1 → `taken`=1; next `pc`=32'h08; `if_id_instr`=NOP; `br_taken_count`=1 under the macro.
- bne not taken: `branch_ne`=1, `equal`=1 → `taken`=0; `pc`=pc+4; `br_count`+1 and `br_taken_count` unchanged under the macro.
- Jump with `stall`=1 for 2 cycles, then released, `if_id_pc4`=32'h4000_0008, index 26'h000_0040 → `pc` and IF/ID hold for 2 cycles, then `pc`=32'h4000_0100.
- Wrap: `pc`=32'hFFFF_FFFC, no branch → next `pc`=0.
- Assert `rst_n`=0 mid-cycle during a taken branch → `pc`=RESET_PC and `if_id_instr`=NOP immediately; counters 0.
